// File: rtl/card_motion_ctrl.sv
// Card sprite animator: loads the start position into the sprite core, unblanks it,
// then steps the position toward the target once per video frame until it arrives.
module card_motion_ctrl #(
  parameter int unsigned STEP     = 4,
  parameter logic [13:0] REG_BASE = 14'h2000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        hide,
  input  logic [10:0] src_x,
  input  logic [10:0] src_y,
  input  logic [10:0] dst_x,
  input  logic [10:0] dst_y,
  output logic        busy,
  output logic        done,
  output logic        cs,
  output logic        write,
  output logic [13:0] addr,
  output logic [31:0] wr_data
);

  localparam int unsigned COORD_W = 11;
  localparam int unsigned ADDR_W  = 14;
  localparam int unsigned DATA_W  = 32;

  localparam logic [COORD_W-1:0] STEP_W      = COORD_W'(STEP);
  localparam logic [ADDR_W-1:0]  ADDR_BYPASS = ADDR_W'(REG_BASE + ADDR_W'(0));
  localparam logic [ADDR_W-1:0]  ADDR_X0     = ADDR_W'(REG_BASE + ADDR_W'(1));
  localparam logic [ADDR_W-1:0]  ADDR_Y0     = ADDR_W'(REG_BASE + ADDR_W'(2));

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_X, S_LOAD_Y, S_SHOW, S_WAIT, S_STEP, S_WR_X, S_WR_Y, S_FINISH
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [COORD_W-1:0] r_cur_x, r_cur_y, r_dst_x, r_dst_y;
  logic [COORD_W-1:0] w_cur_x_nxt, w_cur_y_nxt, w_dst_x_nxt, w_dst_y_nxt;
  logic               w_at_dst;

  logic               w_wr_nxt;
  logic [ADDR_W-1:0]  w_addr_nxt;
  logic [DATA_W-1:0]  w_data_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;

  // Move one coordinate toward its target by at most STEP, never past it.
  function automatic logic [COORD_W-1:0] step_toward(input logic [COORD_W-1:0] cur,
                                                     input logic [COORD_W-1:0] dst);
    logic [COORD_W-1:0] diff;
    if (cur < dst) begin
      diff = dst - cur;
      return cur + ((diff < STEP_W) ? diff : STEP_W);
    end else if (cur > dst) begin
      diff = cur - dst;
      return cur - ((diff < STEP_W) ? diff : STEP_W);
    end
    return cur;
  endfunction

  assign w_at_dst = (r_cur_x == r_dst_x) && (r_cur_y == r_dst_y);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_LOAD_X;
      S_LOAD_X: w_state_nxt = S_LOAD_Y;
      S_LOAD_Y: w_state_nxt = S_SHOW;
      S_SHOW:   w_state_nxt = w_at_dst ? S_FINISH : S_WAIT;
      S_WAIT:   if (frame_tick) w_state_nxt = S_STEP;
      S_STEP:   w_state_nxt = S_WR_X;
      S_WR_X:   w_state_nxt = S_WR_Y;
      S_WR_Y:   w_state_nxt = w_at_dst ? S_FINISH : S_WAIT;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Position datapath: latch on accepted start, advance once per accepted frame
  always_comb begin
    w_cur_x_nxt = r_cur_x;
    w_cur_y_nxt = r_cur_y;
    w_dst_x_nxt = r_dst_x;
    w_dst_y_nxt = r_dst_y;
    if (r_state == S_IDLE && start) begin
      w_cur_x_nxt = src_x;
      w_cur_y_nxt = src_y;
      w_dst_x_nxt = dst_x;
      w_dst_y_nxt = dst_y;
    end else if (r_state == S_STEP) begin
      w_cur_x_nxt = step_toward(r_cur_x, r_dst_x);
      w_cur_y_nxt = step_toward(r_cur_y, r_dst_y);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cur_x <= '0;
      r_cur_y <= '0;
      r_dst_x <= '0;
      r_dst_y <= '0;
    end else begin
      r_cur_x <= w_cur_x_nxt;
      r_cur_y <= w_cur_y_nxt;
      r_dst_x <= w_dst_x_nxt;
      r_dst_y <= w_dst_y_nxt;
    end
  end

  // Output logic: next-cycle bus values, decoded from the state being entered
  always_comb begin
    w_wr_nxt   = 1'b0;
    w_addr_nxt = '0;
    w_data_nxt = '0;
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_FINISH);
    case (w_state_nxt)
      S_IDLE: begin
        if (r_state == S_IDLE && hide && !start) begin
          w_wr_nxt   = 1'b1;
          w_addr_nxt = ADDR_BYPASS;
          w_data_nxt = DATA_W'(1);
        end
      end
      S_LOAD_X, S_WR_X: begin
        w_wr_nxt   = 1'b1;
        w_addr_nxt = ADDR_X0;
        w_data_nxt = DATA_W'(w_cur_x_nxt);
      end
      S_LOAD_Y, S_WR_Y: begin
        w_wr_nxt   = 1'b1;
        w_addr_nxt = ADDR_Y0;
        w_data_nxt = DATA_W'(w_cur_y_nxt);
      end
      S_SHOW: begin
        w_wr_nxt   = 1'b1;
        w_addr_nxt = ADDR_BYPASS;
        w_data_nxt = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      cs      <= 1'b0;
      write   <= 1'b0;
      addr    <= '0;
      wr_data <= '0;
    end else begin
      busy    <= w_busy_nxt;
      done    <= w_done_nxt;
      cs      <= w_wr_nxt;
      write   <= w_wr_nxt;
      addr    <= w_addr_nxt;
      wr_data <= w_data_nxt;
    end
  end

endmodule
